mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported instruction/data memory between the core's fetch path (port IF) and load/store path (port DM).
- Arbitrates round-robin and forwards one transaction at a time over a req/gnt/rvalid protocol.
- Returns read data to the winning requester and flags a bus error on memory timeout.
- Sits between the core top level and the unified memory model, replacing the separate instruction-memory hookup for multi-cycle configurations.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 32, data width; byte-enable width BE_W = DATA_WIDTH/8
TIMEOUT_CYCLES, 64, max cycles waiting for mem_rvalid_i after grant; 0 disables timeout

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
if_req_i  in  1  fetch request, held with if_addr_i until if_gnt_o
if_addr_i  in  ADDR_WIDTH  fetch address
if_gnt_o  out  1  fetch request accepted by memory
if_rvalid_o  out  1  fetch response valid (rsp_* valid)
dm_req_i  in  1  data request, held with fields until dm_gnt_o
dm_addr_i  in  ADDR_WIDTH  data address
dm_we_i  in  1  1=store, 0=load
dm_be_i  in  BE_W  byte enables
dm_wdata_i  in  DATA_WIDTH  store data
dm_gnt_o  out  1  data request accepted by memory
dm_rvalid_o  out  1  data response valid
rsp_rdata_o  out  DATA_WIDTH  response data, shared by both ports
rsp_err_o  out  1  response error (mem_err_i or timeout), shared
mem_req_o  out  1  request to memory
mem_addr_o  out  ADDR_WIDTH  memory address
mem_we_o  out  1  memory write enable
mem_be_o  out  BE_W  memory byte enables
mem_wdata_o  out  DATA_WIDTH  memory write data
mem_gnt_i  in  1  memory accepts mem_req_o this cycle
mem_rvalid_i  in  1  memory response valid, earliest one cycle after gnt
mem_rdata_i  in  DATA_WIDTH  memory read data
mem_err_i  in  1  memory error, qualified by mem_rvalid_i

Behaviour:
- Clock and reset: one clock clk_i; reset rst_ni is asynchronous and active-low.
- Reset: state=IDLE; last_owner=DM, so IF wins the first tie.
- Reset: all outputs and latched request registers are 0.
- Reset mid-transaction aborts immediately; no response is issued.
- FSM IDLE: if any req, pick winner.
  - Only one requesting: that one wins.
  - Both requesting: the port != last_owner wins.
  - Latch owner and request fields into registers; go REQ next cycle.
  - IF fields latch as we=0, be=all-ones, wdata=0.
- FSM REQ: mem_req_o=1, mem_* driven from registers (stable until gnt).
  - On mem_gnt_i: owner's gnt_o=1 the same cycle (combinational), mem_req_o deasserts next cycle.
  - On mem_gnt_i: last_owner<=owner, timeout counter cleared, go RESP.
- FSM RESP: mem_req_o=0.
  - On mem_rvalid_i: owner's rvalid_o=1, rsp_rdata_o=mem_rdata_i, rsp_err_o=mem_err_i (combinational, same cycle); go IDLE.
  - Else counter increments. When counter reaches TIMEOUT_CYCLES: owner's rvalid_o=1, rsp_err_o=1, rsp_rdata_o=0; go IDLE.
  - mem_rvalid_i and timeout in the same cycle: mem_rvalid_i wins.
- Minimum latency: request to gnt_o is 1 cycle when memory grants immediately (IDLE→REQ). Back-to-back throughput is 1 transaction per 3 cycles.
- rvalid_o/rsp_* are 0 outside RESP; gnt_o is 0 outside REQ.
- The non-owner's gnt_o/rvalid_o are always 0.
- mem_rvalid_i or mem_gnt_i outside their state: ignored.
- Requester dropping req before gnt is a protocol violation; the latched transaction still completes and the response is still delivered.
- Counter width: $clog2(TIMEOUT_CYCLES+1). Saturates, no wrap.

Decomposition:
- riscv_pkg additions:
  - arb_state_e {ARB_IDLE, ARB_REQ, ARB_RESP}
  - arb_port_e {ARB_PORT_IF=0, ARB_PORT_DM=1}
  - MEM_TIMEOUT_DEFAULT constant
- Sub-module mem_arb_rr_pick: combinational 2-way round-robin selector with inputs req[1:0], last_owner and output winner. The rest is flat.

Test Plan:
- IF alone at 0x0000_0010, memory gnt after 2 cycles, rvalid 1 cycle later with 0x0050_0093 → if_gnt_o on gnt cycle, if_rvalid_o with rsp_rdata_o=0x0050_0093, rsp_err_o=0; mem_we_o=0, mem_be_o=4'hF.
- IF and DM request in same cycle after reset → IF served first. DM (store 0xDEAD_BEEF, be=4'b0011, addr 0x100) served next with mem_we_o=1 and those fields. Repeat both → order alternates IF, DM, IF.
- DM load, memory never answers, TIMEOUT_CYCLES=4 → dm_rvalid_o with rsp_err_o=1, rsp_rdata_o=0 exactly 4 cycles after grant cycle; FSM back to IDLE, next IF request served normally.
- mem_rvalid_i with mem_err_i=1 on DM load → dm_rvalid_o=1, rsp_err_o=1; if_rvalid_o stays 0.
- rst_ni asserted while in RESP → all outputs 0 asynchronously. After release, the late mem_rvalid_i is ignored and the first tie goes to IF.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
// Imported by the arbiter top and its round-robin selector.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_REQ,
        ARB_RESP
    } arb_state_e;

    typedef enum logic {
        ARB_PORT_IF = 1'b0,
        ARB_PORT_DM = 1'b1
    } arb_port_e;

    localparam int MEM_TIMEOUT_DEFAULT = 64;

    // A disabled timeout (0) still needs a one-bit counter to keep widths legal.
    function automatic int arbCntWidth(input int timeoutCycles);
        return (timeoutCycles < 1) ? 1 : $clog2(timeoutCycles + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Two-way round-robin selector: a lone requester wins, a tie goes to the
// port that did not own the memory last.
module mem_arb_rr_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0] i_req,
    input  arb_port_e  i_last_owner,
    output arb_port_e  o_winner
);

    always_comb begin
        o_winner = ARB_PORT_IF;
        if (i_req == 2'b11) begin
            o_winner = (i_last_owner == ARB_PORT_IF) ? ARB_PORT_DM : ARB_PORT_IF;
        end else if (i_req[ARB_PORT_DM]) begin
            o_winner = ARB_PORT_DM;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch (IF) and load/store (DM)
// paths, one transaction at a time, with a response timeout.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter  int ADDR_WIDTH     = 32,
    parameter  int DATA_WIDTH     = 32,
    parameter  int TIMEOUT_CYCLES = MEM_TIMEOUT_DEFAULT,
    localparam int BE_W           = DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,

    input  logic                  if_req_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    output logic                  if_gnt_o,
    output logic                  if_rvalid_o,

    input  logic                  dm_req_i,
    input  logic [ADDR_WIDTH-1:0] dm_addr_i,
    input  logic                  dm_we_i,
    input  logic [BE_W-1:0]       dm_be_i,
    input  logic [DATA_WIDTH-1:0] dm_wdata_i,
    output logic                  dm_gnt_o,
    output logic                  dm_rvalid_o,

    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,

    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_we_o,
    output logic [BE_W-1:0]       mem_be_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_err_i
);

    localparam int CNT_W = arbCntWidth(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    arb_state_e            r_state;
    arb_port_e             r_owner;
    arb_port_e             r_last_owner;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_we;
    logic [BE_W-1:0]       r_be;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [CNT_W-1:0]      r_cnt;

    logic [1:0]            w_req;
    arb_port_e             w_winner;
    logic                  w_in_req;
    logic                  w_in_resp;
    logic                  w_timeout;
    logic                  w_done;

    assign w_req = {dm_req_i, if_req_i};

    mem_arb_rr_pick u_rr_pick (
        .i_req        (w_req),
        .i_last_owner (r_last_owner),
        .o_winner     (w_winner)
    );

    assign w_in_req  = (r_state == ARB_REQ);
    assign w_in_resp = (r_state == ARB_RESP);
    // The counter holds the number of silent RESP cycles already seen, so the
    // timeout fires on the TIMEOUT_CYCLES-th cycle after the grant.
    assign w_timeout = (TIMEOUT_CYCLES != 0) && w_in_resp && !mem_rvalid_i && (r_cnt == CNT_LAST);
    assign w_done    = w_in_resp && (mem_rvalid_i || w_timeout);

    assign mem_req_o   = w_in_req;
    assign mem_addr_o  = r_addr;
    assign mem_we_o    = r_we;
    assign mem_be_o    = r_be;
    assign mem_wdata_o = r_wdata;

    assign if_gnt_o    = w_in_req && mem_gnt_i && (r_owner == ARB_PORT_IF);
    assign dm_gnt_o    = w_in_req && mem_gnt_i && (r_owner == ARB_PORT_DM);
    assign if_rvalid_o = w_done && (r_owner == ARB_PORT_IF);
    assign dm_rvalid_o = w_done && (r_owner == ARB_PORT_DM);
    assign rsp_rdata_o = (w_in_resp && mem_rvalid_i) ? mem_rdata_i : '0;
    assign rsp_err_o   = w_in_resp && (mem_rvalid_i ? mem_err_i : w_timeout);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= ARB_IDLE;
            r_owner      <= ARB_PORT_IF;
            r_last_owner <= ARB_PORT_DM;
            r_addr       <= '0;
            r_we         <= 1'b0;
            r_be         <= '0;
            r_wdata      <= '0;
            r_cnt        <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (|w_req) begin
                        r_owner <= w_winner;
                        r_state <= ARB_REQ;
                        if (w_winner == ARB_PORT_IF) begin
                            r_addr  <= if_addr_i;
                            r_we    <= 1'b0;
                            r_be    <= '1;
                            r_wdata <= '0;
                        end else begin
                            r_addr  <= dm_addr_i;
                            r_we    <= dm_we_i;
                            r_be    <= dm_be_i;
                            r_wdata <= dm_wdata_i;
                        end
                    end
                end
                ARB_REQ: begin
                    if (mem_gnt_i) begin
                        r_last_owner <= r_owner;
                        r_cnt        <= '0;
                        r_state      <= ARB_RESP;
                    end
                end
                ARB_RESP: begin
                    if (mem_rvalid_i || w_timeout) begin
                        r_state <= ARB_IDLE;
                    end else if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: single fetch, alternating ties,
// timeout, error response and reset in the middle of a transaction.
module tb_mem_port_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic        if_req_i, if_gnt_o, if_rvalid_o;
    logic [31:0] if_addr_i;
    logic        dm_req_i, dm_we_i, dm_gnt_o, dm_rvalid_o;
    logic [31:0] dm_addr_i, dm_wdata_i;
    logic [3:0]  dm_be_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_gnt_i, mem_rvalid_i, mem_err_i;
    logic [31:0] mem_rdata_i;

    int compareCount  = 0;
    int mismatchCount = 0;

    mem_port_arbiter #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .if_req_i     (if_req_i),
        .if_addr_i    (if_addr_i),
        .if_gnt_o     (if_gnt_o),
        .if_rvalid_o  (if_rvalid_o),
        .dm_req_i     (dm_req_i),
        .dm_addr_i    (dm_addr_i),
        .dm_we_i      (dm_we_i),
        .dm_be_i      (dm_be_i),
        .dm_wdata_i   (dm_wdata_i),
        .dm_gnt_o     (dm_gnt_o),
        .dm_rvalid_o  (dm_rvalid_o),
        .rsp_rdata_o  (rsp_rdata_o),
        .rsp_err_o    (rsp_err_o),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .mem_err_i    (mem_err_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic ifReq, input logic [31:0] ifAddr, input logic dmReq,
                                 input logic [31:0] dmAddr, input logic dmWe, input logic [3:0] dmBe,
                                 input logic [31:0] dmWdata);
        if_req_i   = ifReq;
        if_addr_i  = ifAddr;
        dm_req_i   = dmReq;
        dm_addr_i  = dmAddr;
        dm_we_i    = dmWe;
        dm_be_i    = dmBe;
        dm_wdata_i = dmWdata;
    endtask

    task automatic driveMemory(input logic gnt, input logic rvalid, input logic [31:0] rdata, input logic err);
        mem_gnt_i    = gnt;
        mem_rvalid_i = rvalid;
        mem_rdata_i  = rdata;
        mem_err_i    = err;
    endtask

    task automatic nextCycle();
        @(posedge clk_i);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic checkAllZero(input string prefix);
        checkOutput({prefix, " ctl"}, {53'd0, mem_req_o, if_gnt_o, if_rvalid_o, dm_gnt_o, dm_rvalid_o,
                                       rsp_err_o, mem_we_o, mem_be_o}, 64'd0);
        checkOutput({prefix, " rdata"}, rsp_rdata_o, 64'd0);
        checkOutput({prefix, " addr"}, mem_addr_o, 64'd0);
        checkOutput({prefix, " wdata"}, mem_wdata_o, 64'd0);
    endtask

    task automatic doReset();
        rst_ni = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        driveMemory(0, 0, 0, 0);
        repeat (2) @(posedge clk_i);
        #2;
        checkAllZero("reset");
        rst_ni = 1'b1;
        settle();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic expectDm;

        // Single fetch with a memory that grants two cycles late.
        doReset();
        applyStimulus(1, 32'h0000_0010, 0, 0, 0, 0, 0);
        settle();
        checkOutput("t1 idle mem_req", mem_req_o, 0);
        nextCycle(); settle();
        checkOutput("t1 mem_req", mem_req_o, 1);
        checkOutput("t1 mem_addr", mem_addr_o, 32'h0000_0010);
        checkOutput("t1 mem_we", mem_we_o, 0);
        checkOutput("t1 mem_be", mem_be_o, 4'hF);
        checkOutput("t1 mem_wdata", mem_wdata_o, 0);
        checkOutput("t1 early gnt", if_gnt_o, 0);
        nextCycle(); settle();
        checkOutput("t1 addr stable", mem_addr_o, 32'h0000_0010);
        nextCycle();
        driveMemory(1, 0, 0, 0); settle();
        checkOutput("t1 if_gnt", if_gnt_o, 1);
        checkOutput("t1 dm_gnt", dm_gnt_o, 0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        driveMemory(0, 1, 32'h0050_0093, 0); settle();
        checkOutput("t1 resp mem_req", mem_req_o, 0);
        checkOutput("t1 if_rvalid", if_rvalid_o, 1);
        checkOutput("t1 dm_rvalid", dm_rvalid_o, 0);
        checkOutput("t1 rdata", rsp_rdata_o, 32'h0050_0093);
        checkOutput("t1 err", rsp_err_o, 0);
        nextCycle();
        driveMemory(0, 0, 0, 0); settle();
        checkOutput("t1 post rvalid", if_rvalid_o, 0);

        // Both ports keep requesting: ownership must alternate IF, DM, IF, ...
        doReset();
        applyStimulus(1, 32'h0000_0020, 1, 32'h0000_0100, 1, 4'b0011, 32'hDEAD_BEEF);
        for (int i = 0; i < 5; i++) begin
            expectDm = (i % 2) == 1;
            nextCycle(); settle();
            checkOutput($sformatf("t2[%0d] addr", i), mem_addr_o, expectDm ? 32'h0000_0100 : 32'h0000_0020);
            checkOutput($sformatf("t2[%0d] we", i), mem_we_o, expectDm);
            checkOutput($sformatf("t2[%0d] be", i), mem_be_o, expectDm ? 4'b0011 : 4'hF);
            checkOutput($sformatf("t2[%0d] wdata", i), mem_wdata_o, expectDm ? 32'hDEAD_BEEF : 32'h0);
            driveMemory(1, 0, 0, 0); settle();
            checkOutput($sformatf("t2[%0d] if_gnt", i), if_gnt_o, !expectDm);
            checkOutput($sformatf("t2[%0d] dm_gnt", i), dm_gnt_o, expectDm);
            nextCycle();
            driveMemory(0, 1, 32'h0000_1000 + i, 0); settle();
            checkOutput($sformatf("t2[%0d] if_rvalid", i), if_rvalid_o, !expectDm);
            checkOutput($sformatf("t2[%0d] dm_rvalid", i), dm_rvalid_o, expectDm);
            checkOutput($sformatf("t2[%0d] rdata", i), rsp_rdata_o, 32'h0000_1000 + i);
            nextCycle();
            driveMemory(0, 0, 0, 0);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        // DM load that the memory never answers; the error response lands on
        // the fourth cycle after the grant.
        applyStimulus(0, 0, 1, 32'h0000_0200, 0, 4'hF, 0);
        nextCycle(); settle();
        checkOutput("t3 mem_addr", mem_addr_o, 32'h0000_0200);
        driveMemory(1, 0, 0, 0); settle();
        checkOutput("t3 dm_gnt", dm_gnt_o, 1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        driveMemory(0, 0, 32'hFFFF_FFFF, 1);
        for (int k = 1; k <= 3; k++) begin
            settle();
            checkOutput($sformatf("t3 wait%0d dm_rvalid", k), dm_rvalid_o, 0);
            checkOutput($sformatf("t3 wait%0d err", k), rsp_err_o, 0);
            nextCycle();
        end
        settle();
        checkOutput("t3 timeout dm_rvalid", dm_rvalid_o, 1);
        checkOutput("t3 timeout err", rsp_err_o, 1);
        checkOutput("t3 timeout rdata", rsp_rdata_o, 0);
        checkOutput("t3 timeout if_rvalid", if_rvalid_o, 0);
        nextCycle(); settle();
        checkOutput("t3 after dm_rvalid", dm_rvalid_o, 0);
        checkOutput("t3 after err", rsp_err_o, 0);
        driveMemory(0, 0, 0, 0);
        applyStimulus(1, 32'h0000_0030, 0, 0, 0, 0, 0);
        nextCycle(); settle();
        checkOutput("t3 if addr", mem_addr_o, 32'h0000_0030);
        driveMemory(1, 0, 0, 0); settle();
        checkOutput("t3 if_gnt", if_gnt_o, 1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        driveMemory(0, 1, 32'hCAFE_0001, 0); settle();
        checkOutput("t3 if_rvalid", if_rvalid_o, 1);
        checkOutput("t3 if rdata", rsp_rdata_o, 32'hCAFE_0001);
        checkOutput("t3 if err", rsp_err_o, 0);
        nextCycle();
        driveMemory(0, 0, 0, 0);

        // Memory reports an error on a DM load.
        applyStimulus(0, 0, 1, 32'h0000_0300, 0, 4'hF, 0);
        nextCycle(); settle();
        driveMemory(1, 0, 0, 0); settle();
        checkOutput("t4 dm_gnt", dm_gnt_o, 1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        driveMemory(0, 1, 32'h0000_1234, 1); settle();
        checkOutput("t4 dm_rvalid", dm_rvalid_o, 1);
        checkOutput("t4 err", rsp_err_o, 1);
        checkOutput("t4 if_rvalid", if_rvalid_o, 0);
        checkOutput("t4 rdata", rsp_rdata_o, 32'h0000_1234);
        nextCycle();
        driveMemory(0, 0, 0, 0);

        // IF owns the bus when reset hits in RESP; afterwards the tie must still go to IF.
        applyStimulus(1, 32'h0000_0040, 0, 0, 0, 0, 0);
        nextCycle(); settle();
        driveMemory(1, 0, 0, 0); settle();
        checkOutput("t5 if_gnt", if_gnt_o, 1);
        nextCycle();
        applyStimulus(1, 32'h0000_0050, 1, 32'h0000_0500, 0, 4'hF, 0);
        driveMemory(0, 0, 0, 0); settle();
        checkOutput("t5 waiting if_rvalid", if_rvalid_o, 0);
        driveMemory(1, 1, 32'h0000_AAAA, 1);
        rst_ni = 1'b0;
        settle();
        checkAllZero("t5 in reset");
        rst_ni = 1'b1;
        settle();
        checkOutput("t5 late if_rvalid", if_rvalid_o, 0);
        checkOutput("t5 late dm_rvalid", dm_rvalid_o, 0);
        checkOutput("t5 idle if_gnt", if_gnt_o, 0);
        checkOutput("t5 idle dm_gnt", dm_gnt_o, 0);
        checkOutput("t5 late err", rsp_err_o, 0);
        checkOutput("t5 late rdata", rsp_rdata_o, 0);
        nextCycle();
        driveMemory(0, 0, 0, 0); settle();
        checkOutput("t5 tie addr", mem_addr_o, 32'h0000_0050);
        checkOutput("t5 tie we", mem_we_o, 0);
        driveMemory(1, 0, 0, 0); settle();
        checkOutput("t5 tie if_gnt", if_gnt_o, 1);
        checkOutput("t5 tie dm_gnt", dm_gnt_o, 0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        driveMemory(0, 1, 32'h0000_0077, 0); settle();
        checkOutput("t5 tie if_rvalid", if_rvalid_o, 1);
        checkOutput("t5 tie rdata", rsp_rdata_o, 32'h0000_0077);
        nextCycle();
        driveMemory(0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
